icache: RTL



---
 rtl/icache.sv | 138 +++++++++++++
 1 files changed

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with 1-cycle hit latency.
// Misses fill the whole line one word per beat from the memory controller.
module icache #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned WORD_BITS  = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic [31:0] fetch_inst,
  output logic [31:0] fetch_out_addr,
  output logic        mem_valid,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_len,
  input  logic        mem_ready,
  input  logic [31:0] mem_res
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned WORDS = 1 << WORD_BITS;
  localparam int unsigned OFF   = WORD_BITS + 2;
  localparam int unsigned TAG_W = 32 - INDEX_BITS - OFF;

  typedef enum logic {IDLE, FILL} state_e;

  state_e                 state_q, state_d;
  logic [WORD_BITS-1:0]   cnt_q, cnt_d;
  logic [LINES-1:0]       valid_q, valid_d;
  logic                   mem_valid_q, mem_valid_d;
  logic [31:0]            mem_addr_q, mem_addr_d;
  logic                   fetch_ready_q, fetch_ready_d;
  logic [31:0]            fetch_inst_q, fetch_inst_d;
  logic [31:0]            fetch_out_addr_q, fetch_out_addr_d;

  logic [TAG_W-1:0]       tag_q  [LINES];
  logic [31:0]            data_q [LINES][WORDS];
  logic                   data_we, tag_we;

  logic [TAG_W-1:0]       f_tag, m_tag;
  logic [INDEX_BITS-1:0]  f_idx, m_idx;
  logic [WORD_BITS-1:0]   f_word;
  logic                   hit;

  assign f_tag  = fetch_addr[31:OFF+INDEX_BITS];
  assign f_idx  = fetch_addr[OFF+INDEX_BITS-1:OFF];
  assign f_word = fetch_addr[OFF-1:2];
  // The fill line is identified from mem_addr itself, which holds the line base plus the beat offset.
  assign m_tag  = mem_addr_q[31:OFF+INDEX_BITS];
  assign m_idx  = mem_addr_q[OFF+INDEX_BITS-1:OFF];
  assign hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    valid_d          = valid_q;
    mem_valid_d      = mem_valid_q;
    mem_addr_d       = mem_addr_q;
    fetch_ready_d    = rdy_in ? 1'b0 : fetch_ready_q;
    fetch_inst_d     = fetch_inst_q;
    fetch_out_addr_d = fetch_out_addr_q;
    data_we          = 1'b0;
    tag_we           = 1'b0;
    if (rdy_in) begin
      unique case (state_q)
        IDLE: begin
          if (fetch_valid) begin
            if (hit) begin
              fetch_ready_d    = 1'b1;
              fetch_inst_d     = data_q[f_idx][f_word];
              fetch_out_addr_d = fetch_addr & ~32'h3;
            end else begin
              valid_d[f_idx] = 1'b0;
              mem_addr_d     = {fetch_addr[31:OFF], {OFF{1'b0}}};
              cnt_d          = '0;
              mem_valid_d    = 1'b1;
              state_d        = FILL;
            end
          end
        end
        FILL: begin
          if (mem_ready) begin
            data_we = 1'b1;
            if (cnt_q == '1) begin
              tag_we         = 1'b1;
              valid_d[m_idx] = 1'b1;
              mem_valid_d    = 1'b0;
              state_d        = IDLE;
            end else begin
              cnt_d      = cnt_q + 1'b1;
              mem_addr_d = mem_addr_q + 32'd4;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      valid_q          <= '0;
      mem_valid_q      <= 1'b0;
      mem_addr_q       <= '0;
      fetch_ready_q    <= 1'b0;
      fetch_inst_q     <= '0;
      fetch_out_addr_q <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      valid_q          <= valid_d;
      mem_valid_q      <= mem_valid_d;
      mem_addr_q       <= mem_addr_d;
      fetch_ready_q    <= fetch_ready_d;
      fetch_inst_q     <= fetch_inst_d;
      fetch_out_addr_q <= fetch_out_addr_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (data_we) data_q[m_idx][cnt_q] <= mem_res;
    if (tag_we)  tag_q[m_idx]         <= m_tag;
  end

  assign fetch_ready    = fetch_ready_q;
  assign fetch_inst     = fetch_inst_q;
  assign fetch_out_addr = fetch_out_addr_q;
  assign mem_valid      = mem_valid_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wr         = 1'b0;
  assign mem_len        = 3'b010;

endmodule
